rtr_out_port_rcvr: RTL

- Downstream consumer for one output port of the 4-port router. Instantiated 4×, each on an 8-bit slice of the router output bus.
- Watches rcv_rdy and requests packets with data_rd. Captures data_out bytes while valid_out is high and checks addr_out against its port ID.
- Buffers each packet in a FIFO with an end-of-packet marker and presents it to a valid/ready sink.

---
 rtl/rtr_out_port_rcvr.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rtr_out_port_rcvr.sv
// rtr_out_port_rcvr: receiver for one output port of the 4-port router.
// It requests a pending packet from the router and stages the incoming bytes.
// It checks the destination address and queues the bytes, with an
// end-of-packet marker, in a FIFO that feeds a valid/ready sink.
// Optional build macro RCVR_STATS_EN adds saturating packet/byte counters.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transfer; admit a new packet when the FIFO has MAX_PKT free
// REQ   | data_rd high, waiting (bounded by TIMEOUT) for valid_out
// RECV  | packet streaming; staged byte pushed one cycle behind input
module rtr_out_port_rcvr #(
  parameter int PORT_ID    = 0,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_PKT    = 15,
  parameter int TIMEOUT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rcv_rdy,
  input  logic              valid_out,
  input  logic [DATA_W-1:0] addr_out,
  input  logic [DATA_W-1:0] data_out,
  output logic              data_rd,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              clr_err,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_addr,
  output logic              err_ovf
`ifdef RCVR_STATS_EN
  ,
  output logic [15:0]       pkt_count,
  output logic [15:0]       byte_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MAX_PKT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;

  // Admit only when a maximum-length packet is guaranteed to fit.
  localparam logic [CW-1:0] ADMIT_MAX = CW'(FIFO_DEPTH - MAX_PKT);

  logic [1:0]        state;
  logic [TW-1:0]     wait_cnt;
  logic [IW-1:0]     byte_idx;
  logic [DATA_W-1:0] stage_data;
  logic              stage_vld;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W:0]   head;
  logic              push;
  logic              push_last;
  logic              pop;
  logic              full;
  logic              admit;

  logic              timeout_evt;
  logic              addr_evt;
  logic              ovf_evt;

  assign admit   = (count <= ADMIT_MAX);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;
  assign head    = mem[rd_ptr];
  assign m_data  = m_valid ? head[DATA_W-1:0] : '0;
  assign m_last  = m_valid & head[DATA_W];
  assign busy    = (state != S_IDLE);

  assign timeout_evt = (state == S_REQ) && !valid_out && (wait_cnt == '0);
  assign addr_evt    = (state == S_REQ) && valid_out && (addr_out != DATA_W'(PORT_ID));
  assign ovf_evt     = (state == S_RECV) && valid_out && (byte_idx >= IW'(MAX_PKT));

  // Push the staged byte when the next byte arrives (last=0) or the packet ends (last=1).
  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    if (state == S_RECV && stage_vld) begin
      if (!valid_out) begin
        push      = 1'b1;
        push_last = 1'b1;
      end else if (byte_idx < IW'(MAX_PKT)) begin
        push = 1'b1;
      end
    end
  end

  // Request/receive sequencer with the REQ timeout down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      data_rd    <= 1'b0;
      wait_cnt   <= '0;
      byte_idx   <= '0;
      stage_data <= '0;
      stage_vld  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rcv_rdy && admit) begin
            state    <= S_REQ;
            data_rd  <= 1'b1;
            wait_cnt <= TW'(TIMEOUT - 1);
          end
        end
        S_REQ: begin
          if (valid_out) begin
            stage_data <= data_out;
            stage_vld  <= 1'b1;
            byte_idx   <= IW'(1);
            state      <= S_RECV;
          end else if (wait_cnt == '0) begin
            data_rd <= 1'b0;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_RECV: begin
          if (!valid_out) begin
            stage_vld <= 1'b0;
            byte_idx  <= '0;
            data_rd   <= 1'b0;
            state     <= S_IDLE;
          end else if (byte_idx < IW'(MAX_PKT)) begin
            stage_data <= data_out;
            byte_idx   <= byte_idx + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          data_rd <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_timeout <= 1'b0;
      err_addr    <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      err_timeout <= timeout_evt | (err_timeout & ~clr_err);
      err_addr    <= addr_evt    | (err_addr    & ~clr_err);
      err_ovf     <= ovf_evt     | (err_ovf     & ~clr_err);
    end
  end

  // FIFO storage; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, stage_data};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RCVR_STATS_EN
  // Saturating traffic counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count  <= '0;
      byte_count <= '0;
    end else begin
      if (push && push_last && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 1'b1;
      if (push && byte_count != 16'hFFFF) byte_count <= byte_count + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Admission control should make a push into a full FIFO impossible.
  always @(posedge clk) begin
    if (reset) assert (!(push && full));
  end
`endif

endmodule
